palt_nios_sys_nios_jtag_debug_host: RTL
=======================================

PALT_NIOS_SYS_NIOS_JTAG_DEBUG_HOST -- requirements
Module: palt_nios_sys_nios_jtag_debug_host

Interface
Parameters:
REQ-001 SHALL have parameter TCK_DIV, default 4: clk cycles per tck half-period, legal range 2..255.
REQ-002 SHALL have parameter DR_WIDTH, default 38: data-register scan length.
REQ-003 SHALL have parameter IR_WIDTH, default 2: virtual instruction width.

Ports:
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: scan request.
REQ-007 SHALL have port cmd_ready, output, 1: request accepted when cmd_valid && cmd_ready at a clk edge.
REQ-008 SHALL have ports cmd_ir, input, IR_WIDTH, and cmd_dr, input, DR_WIDTH: instruction and shift-in data.
REQ-009 SHALL have port rsp_valid, output, 1, and port rsp_ready, input, 1: response handshake.
REQ-010 SHALL have ports rsp_dr, output, DR_WIDTH, and rsp_ir_out, output, IR_WIDTH: captured tdo data and responder ir_out.
REQ-011 SHALL have ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti, each output, 1; vji_ir_in, output, IR_WIDTH: drives the debug-module virtual JTAG.
REQ-012 SHALL have port vji_tdo, input, 1, and port vji_ir_out, input, IR_WIDTH: responder return path.

Function
REQ-013 SHALL run the FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
REQ-014 SHALL define a tck period as TCK_DIV clk cycles with tck low followed by TCK_DIV clk cycles with tck high; every non-IDLE/RESP state starts on a low phase.
REQ-015 SHALL assert cmd_ready only in IDLE; on acceptance, register cmd_ir and cmd_dr and enter UIR on the next cycle.
REQ-016 UIR SHALL drive vji_ir_in = registered IR and assert vji_uir for exactly 1 tck period; vji_ir_in SHALL hold until the next UIR.
REQ-017 CDR SHALL assert vji_cdr for 1 tck period and sample vji_ir_out into rsp_ir_out on that period's rising tck.
REQ-018 SDR SHALL assert vji_sdr for exactly DR_WIDTH tck periods, shifting LSB first.
REQ-019 vji_tdi SHALL change only at the start of a low phase; vji_tdo SHALL be sampled at the rising tck and shifted into bit DR_WIDTH-1 of the shift register.
REQ-020 UDR SHALL assert vji_udr for 1 tck period; RTI SHALL assert vji_rti for 1 tck period.
REQ-021 At most one of uir/cdr/sdr/udr/rti SHALL be high at any time.
REQ-022 RESP SHALL hold rsp_valid with stable rsp_dr and rsp_ir_out until rsp_ready; it SHALL return to IDLE on the handshake cycle.
REQ-023 SHALL keep vji_tck low in IDLE and RESP.
REQ-024 Latency: with acceptance at edge N, rsp_valid SHALL rise at edge N+1+(DR_WIDTH+4)*2*TCK_DIV, which is N+337 at the default parameters.
REQ-025 SHALL ignore cmd_valid outside IDLE; cmd_dr and cmd_ir changes after acceptance SHALL have no effect.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously force IDLE, all vji_* outputs to 0, rsp_valid to 0, and rsp_dr/rsp_ir_out to 0.
REQ-027 Reset mid-scan SHALL abort without a response; cmd_ready SHALL be 1 on the first clk edge after release.

Configuration
REQ-028 With macro PALT_NIOS_JTAG_HOST_IR_CACHE_EN defined, SHALL skip UIR (IDLE -> CDR) when the accepted cmd_ir equals the last IR loaded since reset.
REQ-029 Under PALT_NIOS_JTAG_HOST_IR_CACHE_EN, the cache SHALL be invalid after reset, and latency SHALL drop by 2*TCK_DIV on a hit.
REQ-030 Without PALT_NIOS_JTAG_HOST_IR_CACHE_EN, UIR SHALL run on every command.

Structure
REQ-031 Package palt_nios_jtag_host_pkg SHALL hold the FSM state enum, default widths and IR encodings: 00 OCIMEM, 01 TRACEMEM, 10 BREAK, 11 TRACECTRL.
REQ-032 Sub-module palt_nios_jtag_host_tckgen SHALL generate vji_tck plus single-cycle fall/rise strobes from TCK_DIV.

Verification
REQ-033 Reset/idle: release reset_n -> cmd_ready=1 next cycle; all vji_* and rsp_valid = 0.
REQ-034 Loopback: vji_tdo = vji_tdi, cmd_dr=38'h2A_5A5A_A5A5, cmd_ir=2'b10 -> rsp_dr=38'h2A_5A5A_A5A5, vji_ir_in=2'b10, rsp_valid at N+337.
REQ-035 Strobe timing: count tck rises per strobe -> uir=1, cdr=1, sdr=38, udr=1, rti=1, with no overlap.
REQ-036 Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_dr stable, cmd_ready=0 throughout.
REQ-037 Reset at 15th SDR bit -> outputs zero immediately; no rsp_valid; next command completes normally.
REQ-038 IR cache (macro defined): two commands with cmd_ir=2'b01 -> second has no vji_uir pulse and latency N+329.

Source files
------------

// File: rtl/palt_nios_jtag_host_pkg.sv
// Shared types and defaults for the Nios II JTAG debug host.
// Holds the scan FSM state encoding, default scan geometry and the
// debug-module virtual instruction encodings.
package palt_nios_jtag_host_pkg;

    // Default scan geometry
    localparam int DEF_TCK_DIV  = 4;
    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

    // Debug-module virtual instructions
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // Scan sequencer states, in traversal order
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } host_state_e;

endpackage

// File: rtl/palt_nios_sys_nios_jtag_debug_host_tckgen.sv
// TCK generator: TCK_DIV clk cycles low, then TCK_DIV clk cycles high.
// Held low with the phase counter cleared whenever i_en is low, so every
// enabled stretch starts at the beginning of a low phase.
// o_rise is high in the last cycle of a low phase (tck rises at the end
// of that cycle); o_fall is high in the last cycle of a high phase, which
// is also the last cycle of a full tck period.
module palt_nios_jtag_host_tckgen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_tck;
    logic       w_last;

    assign w_last = (r_cnt == 8'(TCK_DIV - 1));

    // Phase counter and tck toggle; idle keeps both cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tck  = r_tck;
    assign o_rise = i_en & w_last & ~r_tck;
    assign o_fall = i_en & w_last &  r_tck;

endmodule

// File: rtl/palt_nios_sys_nios_jtag_debug_host.sv
// JTAG debug host: turns one command (IR + DR) into a complete virtual
// JTAG sequence UIR -> CDR -> SDR -> UDR -> RTI toward the Nios II debug
// module, and returns the captured DR and the responder's ir_out.
// Optional: define PALT_NIOS_JTAG_HOST_IR_CACHE_EN to skip UIR when the
// accepted IR matches the last IR loaded since reset.
module palt_nios_sys_nios_jtag_debug_host
    import palt_nios_jtag_host_pkg::*;
#(
    parameter int TCK_DIV  = DEF_TCK_DIV,
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic                vji_tdo,
    input  logic [IR_WIDTH-1:0] vji_ir_out
);

    localparam int BW = $clog2(DR_WIDTH + 1);

    host_state_e         r_state;
    logic                r_run;      // tck generator enable
    logic [IR_WIDTH-1:0] r_ir;
    logic [DR_WIDTH-1:0] r_sh;
    logic [BW-1:0]       r_bitcnt;
    logic [IR_WIDTH-1:0] r_ir_cap;
    logic                r_tdi;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
    logic                r_rti;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_rsp_ir_out;

    logic w_tck;
    logic w_rise;
    logic w_fall;
    logic w_hit;

    palt_nios_jtag_host_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_run),
        .o_tck   (w_tck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

`ifdef PALT_NIOS_JTAG_HOST_IR_CACHE_EN
    logic                r_ir_vld;
    logic [IR_WIDTH-1:0] r_ir_last;

    assign w_hit = r_ir_vld && (cmd_ir == r_ir_last);

    // Remember the IR most recently driven into the responder; reset invalidates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_vld  <= 1'b0;
            r_ir_last <= '0;
        end else if (r_state == ST_UIR && !r_run) begin
            r_ir_vld  <= 1'b1;
            r_ir_last <= r_ir;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Scan sequencer. Each scan state lasts whole tck periods and advances
    // on the fall strobe (end of period). The first scan state spends one
    // setup cycle with tck stopped before its first low phase begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
            r_ir         <= '0;
            r_sh         <= '0;
            r_bitcnt     <= '0;
            r_ir_cap     <= '0;
            r_tdi        <= 1'b0;
            r_uir        <= 1'b0;
            r_cdr        <= 1'b0;
            r_sdr        <= 1'b0;
            r_udr        <= 1'b0;
            r_rti        <= 1'b0;
            r_ir_in      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dr     <= '0;
            r_rsp_ir_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_ir    <= cmd_ir;
                        r_sh    <= cmd_dr;
                        r_state <= w_hit ? ST_CDR : ST_UIR;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (!r_run) begin
                        // Setup cycle: raise the entry strobe with the first low phase
                        r_run <= 1'b1;
                        if (r_state == ST_UIR) begin
                            r_uir   <= 1'b1;
                            r_ir_in <= r_ir;
                        end else begin
                            r_cdr <= 1'b1;
                        end
                    end else begin
                        // Rising tck: sample the responder
                        if (w_rise) begin
                            if (r_state == ST_CDR)
                                r_ir_cap <= vji_ir_out;
                            if (r_state == ST_SDR)
                                r_sh <= {vji_tdo, r_sh[DR_WIDTH-1:1]};
                        end
                        // End of period: advance, tdi only moves here
                        if (w_fall) begin
                            case (r_state)
                                ST_UIR: begin
                                    r_uir   <= 1'b0;
                                    r_cdr   <= 1'b1;
                                    r_state <= ST_CDR;
                                end
                                ST_CDR: begin
                                    r_cdr    <= 1'b0;
                                    r_sdr    <= 1'b1;
                                    r_bitcnt <= '0;
                                    r_tdi    <= r_sh[0];
                                    r_state  <= ST_SDR;
                                end
                                ST_SDR: begin
                                    if (r_bitcnt == BW'(DR_WIDTH - 1)) begin
                                        r_sdr   <= 1'b0;
                                        r_udr   <= 1'b1;
                                        r_tdi   <= 1'b0;
                                        r_state <= ST_UDR;
                                    end else begin
                                        r_bitcnt <= r_bitcnt + BW'(1);
                                        r_tdi    <= r_sh[0];
                                    end
                                end
                                ST_UDR: begin
                                    r_udr   <= 1'b0;
                                    r_rti   <= 1'b1;
                                    r_state <= ST_RTI;
                                end
                                default: begin
                                    r_rti        <= 1'b0;
                                    r_run        <= 1'b0;
                                    r_rsp_valid  <= 1'b1;
                                    r_rsp_dr     <= r_sh;
                                    r_rsp_ir_out <= r_ir_cap;
                                    r_state      <= ST_RESP;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir_out;
    assign vji_tck    = w_tck;
    assign vji_tdi    = r_tdi;
    assign vji_uir    = r_uir;
    assign vji_cdr    = r_cdr;
    assign vji_sdr    = r_sdr;
    assign vji_udr    = r_udr;
    assign vji_rti    = r_rti;
    assign vji_ir_in  = r_ir_in;

endmodule
